// File: rtl/stopwatch_counter_if.sv
// stopwatch_counter_if: control pulses/levels in, BCD time digits out.
// master drives the controls, slave is the counter core.
interface stopwatch_counter_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause_btn;
  logic       clr;
  logic       adj;
  logic       sel;
  logic [3:0] min_l;
  logic [3:0] min_r;
  logic [3:0] sec_l;
  logic [3:0] sec_r;
  logic       running;
  logic       rollover;

  modport master (
    output tick_1hz, tick_2hz, pause_btn,
    output clr, adj, sel,
    input  min_l, min_r, sec_l, sec_r,
    input  running, rollover
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause_btn,
    input  clr, adj, sel,
    output min_l, min_r, sec_l, sec_r,
    output running, rollover
  );
endinterface

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD time-keeping core with
// run/pause, clear and per-field adjust mode.
module stopwatch_counter #(
  parameter int MAX_MIN = 59
) (
  input logic          clk,
  input logic          rst_n,
  stopwatch_counter_if.slave sw
);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam logic [3:0] MAX_L = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_R = 4'(MAX_MIN % 10);

  state_t     r_state;
  state_t     w_state_nx;
  logic [3:0] r_min_l, r_min_r, r_sec_l, r_sec_r;
  logic [3:0] w_min_l_nx, w_min_r_nx;
  logic [3:0] w_sec_l_nx, w_sec_r_nx;
  logic       r_roll, w_roll_nx;

  logic       w_min_max, w_sec_max;
  logic [3:0] w_min_l_inc, w_min_r_inc;
  logic [3:0] w_sec_l_inc, w_sec_r_inc;

  assign w_min_max = (r_min_l == MAX_L) &&
                     (r_min_r == MAX_R);
  assign w_sec_max = (r_sec_l == 4'd5) &&
                     (r_sec_r == 4'd9);

  // Seconds +1 in BCD, 59 wraps to 00.
  assign w_sec_r_inc = (r_sec_r == 4'd9) ? 4'd0
                     : r_sec_r + 4'd1;
  assign w_sec_l_inc = (r_sec_r != 4'd9) ? r_sec_l
                     : (r_sec_l == 4'd5) ? 4'd0
                     : r_sec_l + 4'd1;

  // Minutes +1 in BCD, MAX_MIN wraps to 00.
  assign w_min_r_inc = w_min_max          ? 4'd0
                     : (r_min_r == 4'd9)  ? 4'd0
                     : r_min_r + 4'd1;
  assign w_min_l_inc = w_min_max          ? 4'd0
                     : (r_min_r == 4'd9)  ? r_min_l + 4'd1
                     : r_min_l;

  // Next state/digits: clr beats adjust beats counting.
  always_comb begin
    w_state_nx = r_state;
    w_min_l_nx = r_min_l;
    w_min_r_nx = r_min_r;
    w_sec_l_nx = r_sec_l;
    w_sec_r_nx = r_sec_r;
    w_roll_nx  = 1'b0;
    if (sw.clr) begin
      w_state_nx = PAUSED;
      w_min_l_nx = 4'd0;
      w_min_r_nx = 4'd0;
      w_sec_l_nx = 4'd0;
      w_sec_r_nx = 4'd0;
    end else if (sw.adj) begin
      if (sw.tick_2hz) begin
        if (sw.sel) begin
          w_sec_l_nx = w_sec_l_inc;
          w_sec_r_nx = w_sec_r_inc;
        end else begin
          w_min_l_nx = w_min_l_inc;
          w_min_r_nx = w_min_r_inc;
        end
      end
    end else begin
      if (r_state == RUNNING && sw.tick_1hz) begin
        w_sec_l_nx = w_sec_l_inc;
        w_sec_r_nx = w_sec_r_inc;
        if (w_sec_max) begin
          w_min_l_nx = w_min_l_inc;
          w_min_r_nx = w_min_r_inc;
          w_roll_nx  = w_min_max;
        end
      end
      if (sw.pause_btn) begin
        w_state_nx = (r_state == RUNNING) ? PAUSED
                                          : RUNNING;
      end
    end
  end

  // Run/pause state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= PAUSED;
    else        r_state <= w_state_nx;
  end

  // Digit and rollover registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min_l <= 4'd0;
      r_min_r <= 4'd0;
      r_sec_l <= 4'd0;
      r_sec_r <= 4'd0;
      r_roll  <= 1'b0;
    end else begin
      r_min_l <= w_min_l_nx;
      r_min_r <= w_min_r_nx;
      r_sec_l <= w_sec_l_nx;
      r_sec_r <= w_sec_r_nx;
      r_roll  <= w_roll_nx;
    end
  end

  assign sw.min_l    = r_min_l;
  assign sw.min_r    = r_min_r;
  assign sw.sec_l    = r_sec_l;
  assign sw.sec_r    = r_sec_r;
  assign sw.running  = (r_state == RUNNING);
  assign sw.rollover = r_roll;

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed stimulus with a queued
// scoreboard checked by an independent negedge monitor.
module tb_stopwatch_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stopwatch_counter_if bus ();
  stopwatch_counter_if b9 ();

  stopwatch_counter #(.MAX_MIN(59)) u_dut (
    .clk(clk), .rst_n(rst_n), .sw(bus)
  );
  stopwatch_counter #(.MAX_MIN(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .sw(b9)
  );

  assign b9.tick_1hz  = bus.tick_1hz;
  assign b9.tick_2hz  = bus.tick_2hz;
  assign b9.pause_btn = bus.pause_btn;
  assign b9.clr       = bus.clr;
  assign b9.adj       = bus.adj;
  assign b9.sel       = bus.sel;

  // {tick_1hz, tick_2hz, pause_btn, clr, adj, sel}
  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] T1   = 6'b100000;
  localparam logic [5:0] T2   = 6'b010000;
  localparam logic [5:0] PB   = 6'b001000;
  localparam logic [5:0] CL   = 6'b000100;
  localparam logic [5:0] AD   = 6'b000010;
  localparam logic [5:0] SE   = 6'b000001;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic        run;
    logic        roll;
    bit          c9;
    logic [15:0] d9;
    logic        run9;
    logic        roll9;
    string       tag;
  } exp_t;

  exp_t  q[$];
  exp_t  e;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  string tag = "init";

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] bcd(input int m,
                                      input int s);
    return {4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string nm,
                     input logic [15:0] gd,
                     input logic gr, input logic gro,
                     input logic [15:0] ed,
                     input logic er, input logic ero);
    checks++;
    if ({gd, gr, gro} !== {ed, er, ero}) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h run=%b roll=%b want=%h run=%b roll=%b",
               nm, cyc, gd, gr, gro, ed, er, ero);
    end
  endtask

  // Monitor: compare DUT outputs against due entries.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk(e.tag,
          {bus.min_l, bus.min_r, bus.sec_l, bus.sec_r},
          bus.running, bus.rollover,
          e.d, e.run, e.roll);
      if (e.c9)
        chk({e.tag, "/max9"},
            {b9.min_l, b9.min_r, b9.sec_l, b9.sec_r},
            b9.running, b9.rollover,
            e.d9, e.run9, e.roll9);
    end
  end

  task automatic step(input logic [5:0] v,
                      input logic [15:0] d,
                      input logic run,
                      input logic roll = 1'b0,
                      input bit c9 = 1'b0,
                      input logic [15:0] d9 = 16'h0,
                      input logic run9 = 1'b0,
                      input logic roll9 = 1'b0);
    {bus.tick_1hz, bus.tick_2hz, bus.pause_btn,
     bus.clr, bus.adj, bus.sel} = v;
    q.push_back('{cyc + 1, d, run, roll,
                  c9, d9, run9, roll9, tag});
    @(posedge clk);
    #1;
    {bus.tick_1hz, bus.tick_2hz,
     bus.pause_btn, bus.clr} = 4'b0;
  endtask

  initial begin
    {bus.tick_1hz, bus.tick_2hz, bus.pause_btn,
     bus.clr, bus.adj, bus.sel} = IDLE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset",
        {bus.min_l, bus.min_r, bus.sec_l, bus.sec_r},
        bus.running, bus.rollover, 16'h0, 1'b0, 1'b0);
    chk("reset/max9",
        {b9.min_l, b9.min_r, b9.sec_l, b9.sec_r},
        b9.running, b9.rollover, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tag = "count61";
    step(PB, 16'h0000, 1'b1);
    for (int i = 1; i <= 61; i++) begin
      step(T1, bcd(i / 60, i % 60), 1'b1);
      step(IDLE, bcd(i / 60, i % 60), 1'b1);
    end

    tag = "paused";
    step(PB, 16'h0101, 1'b0);
    repeat (5) step(T1, 16'h0101, 1'b0);

    tag = "clr";
    step(CL, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);

    tag = "tick_pause";
    step(PB, 16'h0000, 1'b1);
    for (int i = 1; i <= 10; i++)
      step(T1, bcd(0, i), 1'b1);
    step(T1 | PB, 16'h0011, 1'b0);
    step(T1 | PB, 16'h0011, 1'b1);
    step(IDLE, 16'h0011, 1'b1);

    tag = "adj_sec";
    step(CL, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    step(PB, 16'h0000, 1'b1);
    for (int i = 1; i <= 58; i++)
      step(AD | SE | T2, bcd(0, i), 1'b1);
    step(AD | SE | T2 | T1, 16'h0059, 1'b1);
    step(AD | SE | T2 | T1, 16'h0000, 1'b1, 1'b0);
    step(AD | SE | T2 | T1, 16'h0001, 1'b1);
    step(AD | SE | T1, 16'h0001, 1'b1);

    tag = "adj_min";
    step(AD | T2 | T1, 16'h0101, 1'b1);
    step(AD | T2, 16'h0201, 1'b1);
    step(AD | PB, 16'h0201, 1'b1);
    step(AD | SE, 16'h0201, 1'b1);
    step(IDLE, 16'h0201, 1'b1);
    step(T1, 16'h0202, 1'b1);

    tag = "clr_all";
    for (int i = 1; i <= 10; i++)
      step(AD | T2, bcd(2 + i, 2), 1'b1);
    for (int i = 1; i <= 32; i++)
      step(AD | SE | T2, bcd(12, 2 + i), 1'b1);
    step(IDLE, 16'h1234, 1'b1);
    step(CL | T1 | PB, 16'h0, 1'b0, 1'b0,
         1'b1, 16'h0, 1'b0, 1'b0);

    tag = "wrap59";
    for (int i = 1; i <= 59; i++)
      step(AD | T2, bcd(i, 0), 1'b0);
    for (int i = 1; i <= 58; i++)
      step(AD | SE | T2, bcd(59, i), 1'b0);
    step(IDLE, 16'h5958, 1'b0);
    step(PB, 16'h5958, 1'b1);
    step(T1, 16'h5959, 1'b1);
    step(IDLE, 16'h5959, 1'b1);
    step(T1, 16'h0000, 1'b1, 1'b1);
    step(IDLE, 16'h0000, 1'b1, 1'b0);

    tag = "wrap9";
    step(CL, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++)
      step(AD | T2, bcd(i, 0), 1'b0, 1'b0,
           1'b1, bcd(i, 0), 1'b0, 1'b0);
    for (int i = 1; i <= 58; i++)
      step(AD | SE | T2, bcd(9, i), 1'b0, 1'b0,
           1'b1, bcd(9, i), 1'b0, 1'b0);
    step(PB, 16'h0958, 1'b1, 1'b0,
         1'b1, 16'h0958, 1'b1, 1'b0);
    step(T1, 16'h0959, 1'b1, 1'b0,
         1'b1, 16'h0959, 1'b1, 1'b0);
    step(T1, 16'h1000, 1'b1, 1'b0,
         1'b1, 16'h0000, 1'b1, 1'b1);
    step(IDLE, 16'h1000, 1'b1, 1'b0,
         1'b1, 16'h0000, 1'b1, 1'b0);

    tag = "preload321";
    step(CL, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++)
      step(AD | T2, bcd(i, 0), 1'b0, 1'b0,
           1'b1, bcd(i, 0), 1'b0, 1'b0);
    for (int i = 1; i <= 21; i++)
      step(AD | SE | T2, bcd(3, i), 1'b0, 1'b0,
           1'b1, bcd(3, i), 1'b0, 1'b0);
    step(PB, 16'h0321, 1'b1, 1'b0,
         1'b1, 16'h0321, 1'b1, 1'b0);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst",
        {bus.min_l, bus.min_r, bus.sec_l, bus.sec_r},
        bus.running, bus.rollover, 16'h0, 1'b0, 1'b0);
    chk("async_rst/max9",
        {b9.min_l, b9.min_r, b9.sec_l, b9.sec_r},
        b9.running, b9.rollover, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tag = "after_rst";
    step(T1, 16'h0000, 1'b0);
    step(PB, 16'h0000, 1'b1);
    step(T1, 16'h0001, 1'b1);

    for (int k = 0; k < 5 && q.size() > 0; k++)
      @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors += q.size();
      checks += q.size();
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-keeping core of the stopwatch. Holds elapsed time as four BCD digits (MM:SS), advances on a one-second tick while running, and supports pause/resume, clear, and a manual adjust mode. The digit outputs feed the seven-segment display stage directly. The `adj` and `sel` levels are shared with that stage so the display knows which field is being adjusted.

## Interface

Parameters:
- `MAX_MIN`, default 59: highest minute value before wrap. Legal range 9..99.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick_1hz`  in  1  single-cycle pulse, once per second; counting enable.
- `tick_2hz`  in  1  single-cycle pulse, twice per second; adjust-mode step enable.
- `pause_btn`  in  1  debounced single-cycle pulse; toggles run/pause.
- `clr`  in  1  debounced single-cycle pulse; synchronous clear.
- `adj`  in  1  level; 1 = adjust mode.
- `sel`  in  1  level; 0 = adjust minutes, 1 = adjust seconds.
- `min_l`  out  4  minutes tens digit, BCD.
- `min_r`  out  4  minutes ones digit, BCD.
- `sec_l`  out  4  seconds tens digit, BCD, range 0..5.
- `sec_r`  out  4  seconds ones digit, BCD, range 0..9.
- `running`  out  1  1 while in RUNNING state.
- `rollover`  out  1  one-cycle pulse on MAX_MIN:59 -> 00:00 wrap during normal counting.

## Operation

- State machine has two states:
  - PAUSED: reset state.
  - RUNNING.
- State transitions:
  - `pause_btn` toggles PAUSED <-> RUNNING when `adj`=0 and `clr`=0.
  - `pause_btn` is ignored while `adj`=1.
  - `clr` forces PAUSED.
- Normal counting:
  - Occurs when state is RUNNING, `adj`=0, and `tick_1hz`=1.
  - Seconds increment 00..59; a carry from 59 -> 00 increments minutes.
  - Minutes count 00..MAX_MIN. The wrap MAX_MIN:59 -> 00:00 asserts `rollover`.
- Adjust mode (`adj`=1):
  - Normal counting is suspended; `tick_1hz` is ignored.
  - On `tick_2hz`, the selected field increments by one.
  - `sel`=1 steps seconds 00..59, wrapping to 00 with no carry into minutes.
  - `sel`=0 steps minutes 00..MAX_MIN, wrapping to 00 without affecting seconds.
  - `rollover` is never asserted in adjust mode.
  - Run/pause state is held unchanged; the previous state resumes when `adj` falls.
- Priority, highest first: `rst_n` low > `clr` > `adj` > normal counting.
- Simultaneous events:
  - `clr` with any tick or `pause_btn`: result is 00:00, PAUSED, no `rollover`.
  - RUNNING, with `tick_1hz` and `pause_btn` in the same cycle: the tick is counted and the state becomes PAUSED.
  - PAUSED, with `tick_1hz` and `pause_btn` in the same cycle: the tick is not counted and the state becomes RUNNING.
  - `tick_1hz` and `tick_2hz` in the same cycle: only the tick matching the current mode acts.
  - A change on `sel` takes effect on the next `tick_2hz`. No partial increments.
- Arithmetic:
  - All digits are BCD; no binary intermediate is exposed.
  - Digit carry: when the ones digit is 9, it becomes 0 and the tens digit increments.
  - Minute wrap compares the {`min_l`,`min_r`} pair against MAX_MIN/10 and MAX_MIN%10.
- Digit values outside range are unreachable; an implementation must never produce them.

## Timing

- Reset value of every output while `rst_n` is low: all digits 0, `running`=0, `rollover`=0. Reset takes effect immediately (asynchronous). Reset release is sampled on the first `clk` rising edge after deassertion.
- All outputs are registered:
  - Digits update on the `clk` edge that samples an active tick; visible one cycle after the tick pulse.
  - `running` updates on the edge that samples `pause_btn` or `clr`.
  - `rollover` is high for exactly the one cycle in which the digits first read 00:00 after the wrap.
- Reset asserted mid-count aborts immediately. No pending increment survives reset.
- Inputs are assumed synchronous to `clk`. Pulses wider than one cycle count once per sampled high cycle, so upstream must supply true single-cycle pulses.

## Test plan

- Reset, then `pause_btn`, then 61 `tick_1hz` pulses -> digits 01:01 and `running`=1. Digits change exactly one cycle after each tick.
- Preload to 59:58 via adjust, resume, 2 ticks -> 59:59 then 00:00. `rollover` is high for one cycle coincident with 00:00. Repeat with MAX_MIN=9 -> wrap 09:59 -> 00:00.
- PAUSED, 5 `tick_1hz` -> digits unchanged. `pause_btn` coincident with a tick while RUNNING at 00:10 -> 00:11 and `running`=0.
- `adj`=1, `sel`=1, from 00:58, 3 `tick_2hz` -> 00:59, 00:00, 00:01 with minutes untouched. Then `sel`=0, 2 `tick_2hz` -> 02:01. `tick_1hz` is ignored throughout. `adj`=0 restores the prior `running` value.
- RUNNING at 12:34: `clr` coincident with `tick_1hz` and `pause_btn` -> 00:00, `running`=0, `rollover`=0.
- `rst_n` pulled low asynchronously between clock edges at 03:21 -> outputs zero before the next edge. After release, counting requires a new `pause_btn`.
